// File: rtl/adc_filter_bank.sv
// ---------------------------------------------------------------------------
// adc_filter_bank
//
// Time-multiplexed boxcar (accumulate-and-dump) averaging filter bank for the
// ADC result stream. Each channel sums 2**n samples and emits the truncated
// (or optionally rounded) average. A channel can instead be bypassed, which
// forwards each sample unchanged. All results go out on one tagged stream
// behind a single-entry output register with a valid/ready handshake.
//
// Ports:
//   SCK          clock
//   POR          synchronous active-high reset
//   adc_data     ADC conversion result (unsigned, IWIDTH bits)
//   adc_channel  channel tag of adc_data
//   adc_sample   one high cycle = one sample
//   adc_anum     per-channel averaging exponent, channel c at [3c+2:3c]
//   adc_bypass   per-channel bypass (no averaging)
//   adc_chen     per-channel enable
//   flt_ready    consumer accepts the held result
//   ovr_clr      clears all overrun flags
//   flt_data     filtered result (OWIDTH bits, extra bits are fraction LSBs)
//   flt_channel  channel of flt_data
//   flt_valid    a result is held on flt_data/flt_channel
//   flt_overrun  sticky per-channel flag: a result was dropped
//   data_ready   every enabled channel has produced at least one result
//
// Build option:
//   ADC_FLT_ROUND_EN  when defined, averages are rounded half-up and
//                     saturated instead of truncated. Bypass is unaffected.
// ---------------------------------------------------------------------------
module adc_filter_bank #(
    parameter int NCH    = 8,
    parameter int CHW    = 3,
    parameter int IWIDTH = 10,
    parameter int OWIDTH = 10,
    parameter int MAXLOG = 3
) (
    input  logic                SCK,
    input  logic                POR,
    input  logic [IWIDTH-1:0]   adc_data,
    input  logic [CHW-1:0]      adc_channel,
    input  logic                adc_sample,
    input  logic [3*NCH-1:0]    adc_anum,
    input  logic [NCH-1:0]      adc_bypass,
    input  logic [NCH-1:0]      adc_chen,
    input  logic                flt_ready,
    input  logic                ovr_clr,
    output logic [OWIDTH-1:0]   flt_data,
    output logic [CHW-1:0]      flt_channel,
    output logic                flt_valid,
    output logic [NCH-1:0]      flt_overrun,
    output logic                data_ready
);

    localparam int ACCW = IWIDTH + MAXLOG;
    localparam int CNTW = (MAXLOG > 0) ? MAXLOG : 1;
    localparam int FRAC = OWIDTH - IWIDTH;
    // One spare bit above the scaled sum absorbs the rounding carry.
    localparam int SW   = ACCW + FRAC + 1;
    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t          state_q, state_d;

    logic [ACCW-1:0]     acc [NCH];
    logic [CNTW-1:0]     cnt [NCH];
    logic [3*NCH-1:0]    anum_q;
    logic [NCH-1:0]      bypass_q;
    logic [NCH-1:0]      chen_q;
    logic [NCH-1:0]      seen;

    logic [NCH-1:0]      cfg_change;
    logic [ACCW-1:0]     sel_acc;
    logic [CNTW-1:0]     sel_cnt;
    logic [2:0]          sel_anum;
    logic                sel_bypass;
    logic                sel_chen;
    logic                sel_change;
    logic                ch_in_range;
    logic                accept;
    logic [2:0]          n_eff;
    logic [ACCW-1:0]     acc_eff;
    logic [CNTW-1:0]     cnt_eff;
    logic [CNTW:0]       last_idx;
    logic                last;
    logic [ACCW-1:0]     sum;
    logic [SW-1:0]       scaled;
    logic [SW-1:0]       shifted;
    logic [OWIDTH-1:0]   avg;
    logic [OWIDTH-1:0]   res_data;
    logic                res_valid;
    logic                load;
    logic                drop;
    logic [NCH-1:0]      ovr_d;
    logic [NCH-1:0]      seen_d;
    logic                data_ready_d;

    // A channel whose live configuration differs from its registered copy
    // restarts its window this cycle.
    always_comb begin
        cfg_change = '0;
        for (int c = 0; c < NCH; c++) begin
            cfg_change[c] = (adc_anum[3*c +: 3] != anum_q[3*c +: 3]) ||
                            (adc_bypass[c] != bypass_q[c]) ||
                            (adc_chen[c] != chen_q[c]);
        end
    end

    // Pick out the state and configuration of the tagged channel. Tags at or
    // above NCH match nothing and are rejected by ch_in_range.
    always_comb begin
        sel_acc    = '0;
        sel_cnt    = '0;
        sel_anum   = '0;
        sel_bypass = 1'b0;
        sel_chen   = 1'b0;
        sel_change = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (adc_channel == CHW'(c)) begin
                sel_acc    = acc[c];
                sel_cnt    = cnt[c];
                sel_anum   = adc_anum[3*c +: 3];
                sel_bypass = adc_bypass[c];
                sel_chen   = adc_chen[c];
                sel_change = cfg_change[c];
            end
        end
    end

    // Sample datapath: the window end is detected on the incoming sample, so
    // the result is ready to register in the same cycle.
    always_comb begin
        ch_in_range = ({1'b0, adc_channel} < NCH_L);
        accept      = adc_sample && ch_in_range && sel_chen;
        n_eff       = (sel_anum > 3'(MAXLOG)) ? 3'(MAXLOG) : sel_anum;
        acc_eff     = sel_change ? '0 : sel_acc;
        cnt_eff     = sel_change ? '0 : sel_cnt;
        last_idx    = (CNTW+1)'((1 << n_eff) - 1);
        last        = ({1'b0, cnt_eff} == last_idx);
        sum         = acc_eff + ACCW'(adc_data);
        scaled      = SW'(sum) << FRAC;
`ifdef ADC_FLT_ROUND_EN
        if (n_eff != 3'd0) begin
            scaled = scaled + (SW'(1) << (n_eff - 3'd1));
        end
`endif
        shifted     = scaled >> n_eff;
        // Only reachable with rounding; truncated averages always fit.
        avg         = (|shifted[SW-1:OWIDTH]) ? '1 : shifted[OWIDTH-1:0];
        res_data    = sel_bypass ? (OWIDTH'(adc_data) << FRAC) : avg;
        res_valid   = accept && (sel_bypass || last);
    end

    // Output register state machine. A new result replaces the held one only
    // if the held one is consumed in the same cycle; otherwise it is dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (res_valid) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (res_valid) begin
                    if (flt_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (flt_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Overrun and first-result flags. A fresh overrun beats ovr_clr, and a
    // result beats a same-cycle config change (the sample opens the new window).
    always_comb begin
        ovr_d  = ovr_clr ? '0 : flt_overrun;
        seen_d = seen;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_change[c]) begin
                seen_d[c] = 1'b0;
            end
            if (res_valid && (adc_channel == CHW'(c))) begin
                seen_d[c] = 1'b1;
                if (drop) begin
                    ovr_d[c] = 1'b1;
                end
            end
        end
        data_ready_d = &(seen_d | ~adc_chen);
    end

    always_ff @(posedge SCK) begin
        if (POR) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge SCK) begin
        if (POR) begin
            flt_data    <= '0;
            flt_channel <= '0;
            flt_overrun <= '0;
            seen        <= '0;
            data_ready  <= 1'b0;
        end else begin
            if (load) begin
                flt_data    <= res_data;
                flt_channel <= adc_channel;
            end
            flt_overrun <= ovr_d;
            seen        <= seen_d;
            data_ready  <= data_ready_d;
        end
    end

    // Per-channel accumulators. Bypassed channels never accumulate, and any
    // configuration change (including disable) discards the partial window.
    always_ff @(posedge SCK) begin
        if (POR) begin
            anum_q   <= '0;
            bypass_q <= '0;
            chen_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            anum_q   <= adc_anum;
            bypass_q <= adc_bypass;
            chen_q   <= adc_chen;
            for (int c = 0; c < NCH; c++) begin
                if (accept && (adc_channel == CHW'(c)) && !adc_bypass[c]) begin
                    if (last) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= sum;
                        cnt[c] <= cnt_eff + 1'b1;
                    end
                end else if (cfg_change[c]) begin
                    acc[c] <= '0;
                    cnt[c] <= '0;
                end
            end
        end
    end

    assign flt_valid = (state_q == FULL);

endmodule

// File: tb/tb_adc_filter_bank.sv
// ---------------------------------------------------------------------------
// tb_adc_filter_bank
//
// Directed bench for adc_filter_bank with NCH=8, IWIDTH=OWIDTH=10, MAXLOG=3.
// A per-cycle table of {configuration, inputs, expected outputs} covers the
// averaging, bypass, interleave, overrun and config-change scenarios; the
// reset-mid-window scenario is written out by hand afterwards.
// ---------------------------------------------------------------------------
module tb_adc_filter_bank;

    localparam int NCH = 8;
    localparam int CHW = 3;
    localparam int IW  = 10;

`ifdef ADC_FLT_ROUND_EN
    localparam logic [9:0] T1_EXP = 10'd102;
`else
    localparam logic [9:0] T1_EXP = 10'd101;
`endif

    logic              SCK = 1'b0;
    logic              POR;
    logic [IW-1:0]     adc_data;
    logic [CHW-1:0]    adc_channel;
    logic              adc_sample;
    logic [3*NCH-1:0]  adc_anum;
    logic [NCH-1:0]    adc_bypass;
    logic [NCH-1:0]    adc_chen;
    logic              flt_ready;
    logic              ovr_clr;
    logic [IW-1:0]     flt_data;
    logic [CHW-1:0]    flt_channel;
    logic              flt_valid;
    logic [NCH-1:0]    flt_overrun;
    logic              data_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] anum;
        logic [7:0]  byp;
        logic [7:0]  chen;
        logic        smp;
        logic [2:0]  ch;
        logic [9:0]  dat;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [2:0]  ech;
        logic [9:0]  edat;
        logic [7:0]  eovr;
        logic        edr;
    } vec_t;

    vec_t vecs[$];

    adc_filter_bank #(
        .NCH(NCH), .CHW(CHW), .IWIDTH(IW), .OWIDTH(IW), .MAXLOG(3)
    ) dut (
        .SCK(SCK),
        .POR(POR),
        .adc_data(adc_data),
        .adc_channel(adc_channel),
        .adc_sample(adc_sample),
        .adc_anum(adc_anum),
        .adc_bypass(adc_bypass),
        .adc_chen(adc_chen),
        .flt_ready(flt_ready),
        .ovr_clr(ovr_clr),
        .flt_data(flt_data),
        .flt_channel(flt_channel),
        .flt_valid(flt_valid),
        .flt_overrun(flt_overrun),
        .data_ready(data_ready)
    );

    always #5 SCK = ~SCK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge.
    task automatic applyStimulus(input vec_t v);
        adc_anum    = v.anum;
        adc_bypass  = v.byp;
        adc_chen    = v.chen;
        adc_sample  = v.smp;
        adc_channel = v.ch;
        adc_data    = v.dat;
        flt_ready   = v.rdy;
        ovr_clr     = v.clr;
        @(posedge SCK);
        #1;
    endtask

    task automatic addVec(input logic [23:0] anum, input logic [7:0] byp, input logic [7:0] chen,
                          input logic smp, input logic [2:0] ch, input logic [9:0] dat,
                          input logic rdy, input logic clr,
                          input logic ev, input logic [2:0] ech, input logic [9:0] edat,
                          input logic [7:0] eovr, input logic edr);
        vec_t v;
        v.anum = anum; v.byp = byp; v.chen = chen;
        v.smp = smp; v.ch = ch; v.dat = dat; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ech = ech; v.edat = edat; v.eovr = eovr; v.edr = edr;
        vecs.push_back(v);
    endtask

    task automatic step(input logic smp, input logic [2:0] ch, input logic [9:0] dat);
        vec_t v;
        v.anum = adc_anum; v.byp = adc_bypass; v.chen = adc_chen;
        v.smp = smp; v.ch = ch; v.dat = dat; v.rdy = 1'b1; v.clr = 1'b0;
        v.ev = 1'b0; v.ech = '0; v.edat = '0; v.eovr = '0; v.edr = 1'b0;
        applyStimulus(v);
    endtask

    initial begin
        // ch1 anum=2: four samples averaged
        addVec(24'h000010, 8'h00, 8'h02, 1, 1, 10'd100, 1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000010, 8'h00, 8'h02, 1, 1, 10'd101, 1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000010, 8'h00, 8'h02, 1, 1, 10'd102, 1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000010, 8'h00, 8'h02, 1, 1, 10'd103, 1, 0,  1, 1, T1_EXP, 8'h00, 1);
        addVec(24'h000010, 8'h00, 8'h02, 0, 0, 10'd0,   1, 0,  0, 0, 0,      8'h00, 1);
        // ch4 bypass with anum=5 ignored
        addVec(24'h005010, 8'h10, 8'h12, 1, 4, 10'h3FF, 1, 0,  1, 4, 10'h3FF, 8'h00, 1);
        addVec(24'h005010, 8'h10, 8'h12, 0, 0, 10'd0,   1, 0,  0, 0, 0,      8'h00, 1);
        // ch1/ch2 anum=1 interleaved
        addVec(24'h000048, 8'h00, 8'h06, 1, 1, 10'd10,  1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000048, 8'h00, 8'h06, 1, 2, 10'd20,  1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000048, 8'h00, 8'h06, 1, 1, 10'd12,  1, 0,  1, 1, 10'd11, 8'h00, 0);
        addVec(24'h000048, 8'h00, 8'h06, 1, 2, 10'd22,  1, 0,  1, 2, 10'd21, 8'h00, 1);
        addVec(24'h000048, 8'h00, 8'h06, 0, 0, 10'd0,   1, 0,  0, 0, 0,      8'h00, 1);
        // backpressure: second result dropped, overrun flagged, then cleared
        addVec(24'h000000, 8'h00, 8'h06, 1, 1, 10'd7,   0, 0,  1, 1, 10'd7,  8'h00, 0);
        addVec(24'h000000, 8'h00, 8'h06, 1, 2, 10'd9,   0, 0,  1, 1, 10'd7,  8'h04, 1);
        addVec(24'h000000, 8'h00, 8'h06, 0, 0, 10'd0,   0, 1,  1, 1, 10'd7,  8'h00, 1);
        addVec(24'h000000, 8'h00, 8'h06, 0, 0, 10'd0,   1, 0,  0, 0, 0,      8'h00, 1);
        // overrun in the same cycle as ovr_clr keeps the bit set
        addVec(24'h000000, 8'h00, 8'h06, 1, 1, 10'd7,   0, 0,  1, 1, 10'd7,  8'h00, 1);
        addVec(24'h000000, 8'h00, 8'h06, 1, 2, 10'd9,   0, 1,  1, 1, 10'd7,  8'h04, 1);
        addVec(24'h000000, 8'h00, 8'h06, 0, 0, 10'd0,   1, 1,  0, 0, 0,      8'h00, 1);
        // ch3 anum=3, window restarted by anum->0 on the same cycle as a sample
        addVec(24'h000600, 8'h00, 8'h08, 1, 3, 10'd200, 1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000600, 8'h00, 8'h08, 1, 3, 10'd200, 1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000600, 8'h00, 8'h08, 1, 3, 10'd200, 1, 0,  0, 0, 0,      8'h00, 0);
        addVec(24'h000000, 8'h00, 8'h08, 1, 3, 10'd50,  1, 0,  1, 3, 10'd50, 8'h00, 1);
        addVec(24'h000000, 8'h00, 8'h08, 0, 0, 10'd0,   1, 0,  0, 0, 0,      8'h00, 1);
        // sample on a disabled channel is ignored
        addVec(24'h000000, 8'h00, 8'h08, 1, 5, 10'd77,  1, 0,  0, 0, 0,      8'h00, 1);

        // Reset with all inputs quiet
        POR = 1'b1;
        adc_anum = '0; adc_bypass = '0; adc_chen = '0; adc_sample = 1'b0;
        adc_channel = '0; adc_data = '0; flt_ready = 1'b1; ovr_clr = 1'b0;
        repeat (2) @(posedge SCK);
        #1;
        checkOutput("rst_valid", 32'(flt_valid), 32'd0);
        checkOutput("rst_data", 32'(flt_data), 32'd0);
        checkOutput("rst_chan", 32'(flt_channel), 32'd0);
        checkOutput("rst_ovr", 32'(flt_overrun), 32'd0);
        checkOutput("rst_dready", 32'(data_ready), 32'd0);
        POR = 1'b0;
        @(posedge SCK);
        #1;
        checkOutput("noch_dready", 32'(data_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_valid", i), 32'(flt_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                checkOutput($sformatf("v%0d_chan", i), 32'(flt_channel), 32'(vecs[i].ech));
                checkOutput($sformatf("v%0d_data", i), 32'(flt_data), 32'(vecs[i].edat));
            end
            checkOutput($sformatf("v%0d_ovr", i), 32'(flt_overrun), 32'(vecs[i].eovr));
            checkOutput($sformatf("v%0d_dready", i), 32'(data_ready), 32'(vecs[i].edr));
        end

        // Reset part-way through a window must discard the partial sum
        adc_anum = 24'h000010; adc_bypass = '0; adc_chen = 8'h02;
        step(1'b1, 3'd1, 10'd300);
        checkOutput("por_pre1_valid", 32'(flt_valid), 32'd0);
        step(1'b1, 3'd1, 10'd300);
        checkOutput("por_pre2_valid", 32'(flt_valid), 32'd0);
        POR = 1'b1;
        step(1'b0, 3'd0, 10'd0);
        checkOutput("por_valid", 32'(flt_valid), 32'd0);
        checkOutput("por_data", 32'(flt_data), 32'd0);
        checkOutput("por_chan", 32'(flt_channel), 32'd0);
        checkOutput("por_dready", 32'(data_ready), 32'd0);
        POR = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'd1, 10'd8);
            checkOutput($sformatf("por_s%0d_valid", k), 32'(flt_valid), 32'd0);
            checkOutput($sformatf("por_s%0d_dready", k), 32'(data_ready), 32'd0);
        end
        step(1'b1, 3'd1, 10'd8);
        checkOutput("por_res_valid", 32'(flt_valid), 32'd1);
        checkOutput("por_res_chan", 32'(flt_channel), 32'd1);
        checkOutput("por_res_data", 32'(flt_data), 32'd8);
        checkOutput("por_res_dready", 32'(data_ready), 32'd1);
        step(1'b0, 3'd0, 10'd0);
        checkOutput("por_idle_valid", 32'(flt_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
